// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
// Imported by serial_subtractor; FullSubtractor needs nothing from here.
package serial_subtractor_pkg;

  // Default operand/result width in bits.
  localparam int DEFAULT_WIDTH = 16;

  // IDLE: waiting for a start; SHIFT: one bit per cycle; DONE: result pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor, purely combinational.
// Ports: a, b, borrow_in -> diff = a-b-borrow_in (mod 2), borrow_out.
// Latency: none; no flow control.
module FullSubtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  // Borrow when b exceeds a, or when they match and a borrow is pending.
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock through a single FullSubtractor.
// Ports: clk_in/reset_in; start_in, a_in, b_in request; ready_out, done_out
// handshake; diff_out, borrow_out, overflow_out, zero_out hold the last result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             overflow_out,
  output logic             zero_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  // Only the upper WIDTH-1 result bits need storage: the final bit is
  // produced combinationally in the last SHIFT cycle.
  logic [WIDTH-2:0]   res_sr;
  logic               bw;
  logic [CNT_W-1:0]   cnt;

  logic               bit_d;
  logic               bit_bw;
  logic               last_bit;
  logic [WIDTH-1:0]   diff_next;

  FullSubtractor u_fs (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (bw),
    .diff       (bit_d),
    .borrow_out (bit_bw)
  );

  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign diff_next = {bit_d, res_sr};

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      res_sr       <= '0;
      bw           <= 1'b0;
      cnt          <= '0;
      ready_out    <= 1'b1;
      done_out     <= 1'b0;
      diff_out     <= '0;
      borrow_out   <= 1'b0;
      overflow_out <= 1'b0;
      zero_out     <= 1'b1;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            a_sr      <= a_in;
            b_sr      <= b_in;
            bw        <= 1'b0;
            cnt       <= '0;
            state     <= SHIFT;
            ready_out <= 1'b0;
          end else begin
            state     <= IDLE;
          end
        end
        SHIFT: begin
          res_sr <= diff_next[WIDTH-1:1];
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          bw     <= bit_bw;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // a_sr[0]/b_sr[0] now hold the original operand MSBs and
            // bit_d is the result MSB.
            state        <= DONE;
            ready_out    <= 1'b1;
            done_out     <= 1'b1;
            diff_out     <= diff_next;
            borrow_out   <= bit_bw;
            overflow_out <= (a_sr[0] != b_sr[0]) && (bit_d != a_sr[0]);
            zero_out     <= (diff_next == '0);
          end
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         reset_in = 1'b0;
  logic         start_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ready_out;
  logic         done_out;
  logic [W-1:0] diff_out;
  logic         borrow_out;
  logic         overflow_out;
  logic         zero_out;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .ready_out    (ready_out),
    .done_out     (done_out),
    .diff_out     (diff_out),
    .borrow_out   (borrow_out),
    .overflow_out (overflow_out),
    .zero_out     (zero_out)
  );

  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Cycle counter advances on every edge; an accepted operation finishes
  // W edges after acceptance and is visible for exactly one cycle.
  longint       cyc = 0;
  logic         m_pend = 1'b0;
  longint       m_done_cyc = 0;
  logic         m_rdy;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] e_diff = '0;
  logic         e_borrow = 1'b0;
  logic         e_ovf = 1'b0;
  logic         e_zero = 1'b1;
  longint       sdiff;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      m_pend   = 1'b0;
      e_diff   = '0;
      e_borrow = 1'b0;
      e_ovf    = 1'b0;
      e_zero   = 1'b1;
    end else begin
      m_rdy = !m_pend || (cyc == m_done_cyc);
      if (m_pend && cyc == m_done_cyc) m_pend = 1'b0;
      cyc = cyc + 1;
      if (m_rdy && start_in) begin
        m_pend     = 1'b1;
        m_a        = a_in;
        m_b        = b_in;
        m_done_cyc = cyc + W;
      end
      if (m_pend && cyc == m_done_cyc) begin
        e_diff   = W'(longint'(m_a) - longint'(m_b));
        e_borrow = (m_a < m_b);
        sdiff    = longint'($signed(m_a)) - longint'($signed(m_b));
        e_ovf    = (sdiff > (64'sd1 <<< (W-1)) - 1) || (sdiff < -(64'sd1 <<< (W-1)));
        e_zero   = (m_a == m_b);
      end
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk_in) begin
    logic exp_done, exp_ready;
    if (cmp_en) begin
      exp_done  = m_pend && (cyc == m_done_cyc);
      exp_ready = !m_pend || (cyc == m_done_cyc);
      chk($sformatf("cycle %0d rdy/done/brw/ovf/zero/diff", cyc),
          {ready_out, done_out, borrow_out, overflow_out, zero_out, diff_out},
          {exp_ready, exp_done, e_borrow, e_ovf, e_zero, e_diff});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ready();
    int k = 0;
    @(negedge clk_in);
    while (!ready_out && k < 40) begin
      @(negedge clk_in);
      k++;
    end
    if (!ready_out) chk("wait_ready timeout", 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
    int lat = 0;
    wait_ready();
    start_in = 1'b1; a_in = a; b_in = b;
    @(posedge clk_in); #2;
    start_in = 1'b0; a_in = ~a; b_in = ~b;
    do begin
      @(negedge clk_in);
      lat++;
    end while (!done_out && lat < 40);
    chk({nm, " latency"}, lat, 17);
    chk({nm, " diff"}, diff_out, ed);
    chk({nm, " borrow"}, borrow_out, eb);
    chk({nm, " overflow"}, overflow_out, eo);
    chk({nm, " zero"}, zero_out, ez);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    #1 reset_in = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset ready", ready_out, 1);
    chk("reset done", done_out, 0);
    chk("reset diff", diff_out, 0);
    chk("reset zero", zero_out, 1);
    #1 reset_in = 1'b0;

    run_op("basic",    16'h0005, 16'h0003, 16'h0002, 0, 0, 0);
    run_op("wrap",     16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0);
    run_op("sovf",     16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0);
    run_op("equal",    16'hA5A5, 16'hA5A5, 16'h0000, 0, 0, 1);
    run_op("negovf",   16'h7FFF, 16'hFFFF, 16'h8000, 1, 1, 0);

    // Start while busy is ignored; then a start in the DONE cycle.
    wait_ready();
    start_in = 1'b1; a_in = 16'h1234; b_in = 16'h0234;
    @(posedge clk_in); #2 start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2 start_in = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001;
    @(posedge clk_in); #2 start_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_in);
      lat++;
    end while (!done_out && lat < 40);
    chk("busy done seen", done_out, 1);
    chk("busy diff", diff_out, 16'h1000);
    chk("busy borrow", borrow_out, 0);
    start_in = 1'b1; a_in = 16'h0003; b_in = 16'h0005;
    @(posedge clk_in); #2 start_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk_in);
      lat++;
      if (lat == 8) chk("b2b held diff", diff_out, 16'h1000);
    end while (!done_out && lat < 40);
    chk("b2b latency", lat, 17);
    chk("b2b diff", diff_out, 16'hFFFE);
    chk("b2b borrow", borrow_out, 1);

    // Reset five cycles into SHIFT.
    wait_ready();
    start_in = 1'b1; a_in = 16'h4321; b_in = 16'h0001;
    @(posedge clk_in); #2 start_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #2 reset_in = 1'b1;
    #1;
    chk("midrst ready", ready_out, 1);
    chk("midrst diff", diff_out, 0);
    chk("midrst zero", zero_out, 1);
    @(posedge clk_in); #2 reset_in = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk_in);
      if (done_out) ndone++;
    end
    chk("midrst no done", ndone, 0);
    run_op("postrst", 16'h0100, 16'h0001, 16'h00FF, 0, 0, 0);

    // Randomized traffic with occasional async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_in); #2;
      start_in = ($urandom % 4 == 0);
      a_in = pick();
      b_in = pick();
      if (i % 700 == 350) begin
        reset_in = 1'b1;
        @(posedge clk_in); #2 reset_in = 1'b0;
      end
    end
    start_in = 1'b0;
    repeat (25) @(posedge clk_in);
    @(negedge clk_in); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
